// File: rtl/pipe_pulse_pkg.sv
// pipe_pulse_pkg: shared edge-mode encodings and stretch-counter sizing
package pipe_pulse_pkg;
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;
  function automatic int cnt_width(input int len);
    return $clog2(len + 1);
  endfunction
endpackage

// File: rtl/pipe_pulse_channel.sv
// pipe_pulse_channel: edge detect, pulse stretch, delay line and sticky overrun for one channel
module pipe_pulse_channel
  import pipe_pulse_pkg::*;
#(
  parameter int DELAY     = 2,
  parameter int PULSE_LEN = 1,
  parameter int EDGE_MODE = EDGE_RISE,
  parameter int RETRIGGER = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic s,
  input  logic pipe_in,
  input  logic clr_overrun,
  output logic pipe_out,
  output logic busy,
  output logic overrun
);
  localparam int CW = cnt_width(PULSE_LEN);
  localparam logic [CW-1:0] LEN_V = CW'(PULSE_LEN);
  logic s_prev, edge_det, trigger, active_cnt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [DELAY-1:0] stg;
  always_comb begin
    edge_det = (EDGE_MODE == EDGE_FALL) ? (~s & s_prev) :
               (EDGE_MODE == EDGE_BOTH) ? (s ^ s_prev) : (s & ~s_prev);
    trigger = enable & (edge_det | pipe_in);
    active_cnt = cnt != '0;
    cnt_nxt = (trigger & (~active_cnt | (RETRIGGER != 0))) ? LEN_V :
              active_cnt ? cnt - 1'b1 : cnt;
  end
  // stg[0] is the registered counter-active stage; the rest form the delay line
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_prev  <= 1'b0;
      cnt     <= '0;
      stg     <= '0;
      overrun <= 1'b0;
    end else begin
      s_prev  <= s;
      cnt     <= cnt_nxt;
      stg     <= DELAY'({stg, active_cnt});
      overrun <= (trigger & active_cnt & (RETRIGGER == 0)) | (overrun & ~clr_overrun);
    end
  end
  assign pipe_out = stg[DELAY-1];
  assign busy     = |stg;
endmodule

// File: rtl/pipe_pulse_chain.sv
// pipe_pulse_chain: multi-channel delayed, stretched trigger pulse generator for daisy-chaining
module pipe_pulse_chain
  import pipe_pulse_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int DELAY     = 2,
  parameter int PULSE_LEN = 1,
  parameter int EDGE_MODE = EDGE_RISE,
  parameter int RETRIGGER = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [CHANNELS-1:0] s,
  input  logic [CHANNELS-1:0] pipe_in,
  output logic [CHANNELS-1:0] pipe_out,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] overrun,
  input  logic                clr_overrun
);
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pipe_pulse_channel #(
      .DELAY(DELAY), .PULSE_LEN(PULSE_LEN), .EDGE_MODE(EDGE_MODE), .RETRIGGER(RETRIGGER)
    ) u_ch (
      .clk(clk), .reset(reset), .enable(enable), .s(s[i]), .pipe_in(pipe_in[i]),
      .clr_overrun(clr_overrun), .pipe_out(pipe_out[i]), .busy(busy[i]), .overrun(overrun[i])
    );
  end
endmodule

// File: tb/tb_pipe_pulse_chain.sv
// tb_pipe_pulse_chain: scoreboard bench over six parameter variants sharing clock, reset, enable
module tb_pipe_pulse_chain;
  localparam int N = 6;
  localparam int DLY [N] = '{2, 3, 2, 2, 2, 2};
  localparam int LEN [N] = '{1, 4, 3, 3, 1, 1};
  localparam int EM  [N] = '{0, 0, 0, 0, 2, 1};
  localparam int RT  [N] = '{1, 1, 1, 0, 1, 1};
  typedef struct {int g; int c; int e;} exp_t;
  logic clk = 0, reset = 1, enable = 1, clr = 0;
  logic [3:0] s [N], pin [N], po [N], bz [N], ov [N];
  int edge_n = 0, checks = 0, passes = 0;
  exp_t sb [$];

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  for (genvar i = 0; i < N; i++) begin : g_dut
    pipe_pulse_chain #(
      .CHANNELS(4), .DELAY(DLY[i]), .PULSE_LEN(LEN[i]), .EDGE_MODE(EM[i]), .RETRIGGER(RT[i])
    ) u_dut (
      .clk(clk), .reset(reset), .enable(enable), .s(s[i]), .pipe_in(pin[i]),
      .pipe_out(po[i]), .busy(bz[i]), .overrun(ov[i]), .clr_overrun(clr)
    );
  end

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act == want) passes++;
    else $display("FAIL %s: got %0h want %0h", name, act, want);
  endtask

  task automatic expect_run(input int g, input int c, input int first, input int n);
    for (int k = 0; k < n; k++) sb.push_back('{g, c, first + k});
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // every high pipe_out bit must match a queued (instance, channel, edge) entry
  always @(negedge clk) begin
    if (!reset) begin
      for (int g = 0; g < N; g++)
        for (int c = 0; c < 4; c++)
          if (po[g][c]) begin
            int k;
            k = -1;
            for (int i = 0; i < sb.size(); i++)
              if (sb[i].g == g && sb[i].c == c && sb[i].e == edge_n) k = i;
            checks++;
            if (k >= 0) begin
              passes++;
              sb.delete(k);
            end else
              $display("FAIL pulse inst%0d ch%0d after edge %0d: pipe_out=1 want 0", g, c, edge_n);
          end
    end
  end

  initial begin
    for (int g = 0; g < N; g++) begin
      s[g] = '0;
      pin[g] = '0;
    end
    #12;
    for (int g = 0; g < N; g++)
      chk($sformatf("reset_state%0d", g), int'({po[g], bz[g], ov[g]}), 0);
    @(negedge clk) reset = 0;
    tick(2);
    // rising edge on defaults: one-cycle pulse two edges after sampling
    s[0][0] = 1'b1;
    expect_run(0, 0, edge_n + 3, 1);
    tick(4);
    s[0][0] = 1'b0;
    tick(3);
    // one-cycle pipe_in, LEN=4 DELAY=3; busy spans t0+1..t0+6
    pin[1][1] = 1'b1;
    expect_run(1, 1, edge_n + 4, 4);
    for (int k = 0; k < 8; k++) begin
      tick(1);
      pin[1][1] = 1'b0;
      chk($sformatf("busy_k%0d", k), int'(bz[1][1]), int'(k >= 1 && k <= 6));
    end
    tick(2);
    // triggers two edges apart, LEN=3: retrigger extends to 5, no-retrigger gives 3 + overrun
    pin[2][2] = 1'b1;
    pin[3][2] = 1'b1;
    expect_run(2, 2, edge_n + 3, 5);
    expect_run(3, 2, edge_n + 3, 3);
    tick(1);
    pin[2][2] = 1'b0;
    pin[3][2] = 1'b0;
    tick(1);
    chk("ovr_before_retrig", int'(ov[3]), 0);
    pin[2][2] = 1'b1;
    pin[3][2] = 1'b1;
    tick(1);
    pin[2][2] = 1'b0;
    pin[3][2] = 1'b0;
    chk("ovr_retrig0", int'(ov[3]), 4'b0100);
    chk("ovr_retrig1", int'(ov[2]), 0);
    tick(8);
    // s high for 4 cycles: both-edge mode pulses twice, falling mode once
    s[4][3] = 1'b1;
    s[5][3] = 1'b1;
    expect_run(4, 3, edge_n + 3, 1);
    tick(4);
    s[4][3] = 1'b0;
    s[5][3] = 1'b0;
    expect_run(4, 3, edge_n + 3, 1);
    expect_run(5, 3, edge_n + 3, 1);
    tick(6);
    // overrun set wins over clr_overrun in the same cycle
    pin[3][1] = 1'b1;
    expect_run(3, 1, edge_n + 3, 3);
    tick(2);
    clr = 1'b1;
    chk("ovr_pre_clr", int'(ov[3]), 4'b0110);
    tick(1);
    pin[3][1] = 1'b0;
    clr = 1'b0;
    chk("ovr_set_wins", int'(ov[3]), 4'b0010);
    tick(6);
    // edges while disabled are lost and never resurface
    enable = 1'b0;
    for (int g = 0; g < N; g++) s[g] = 4'hF;
    tick(2);
    enable = 1'b1;
    for (int g = 0; g < N; g++) chk($sformatf("disabled_busy%0d", g), int'(bz[g]), 0);
    tick(6);
    // async reset mid-pulse, then s high at release starts a fresh pulse
    pin[1][0] = 1'b1;
    expect_run(1, 0, edge_n + 4, 4);
    tick(1);
    pin[1][0] = 1'b0;
    tick(3);
    chk("mid_pulse", int'(po[1]), 4'b0001);
    chk("ovr_before_rst", int'(ov[3]), 4'b0010);
    #2 reset = 1'b1;
    #1;
    for (int g = 0; g < N; g++)
      chk($sformatf("async_reset%0d", g), int'({po[g], bz[g], ov[g]}), 0);
    for (int k = sb.size() - 1; k >= 0; k--)
      if (sb[k].e > edge_n) sb.delete(k);
    @(negedge clk) reset = 1'b0;
    for (int g = 0; g < N; g++)
      if (EM[g] != 1)
        for (int c = 0; c < 4; c++) expect_run(g, c, edge_n + 1 + DLY[g], LEN[g]);
    tick(10);
    foreach (sb[k]) begin
      checks++;
      $display("FAIL missing inst%0d ch%0d edge %0d: pipe_out=0 want 1", sb[k].g, sb[k].c, sb[k].e);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
